// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/refill signals and the shared main-memory port of the
// refill arbiter; master is the arbiter's view, slave the caches'/memory's view.
interface cache_mem_arbiter_if #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_rvalid;
  logic              ic_done;
  logic              ic_stall;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [BEAT_W-1:0] dc_beat;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_rvalid;
  logic              dc_done;
  logic              dc_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_rvalid, ic_done, ic_stall,
           dc_beat, dc_rdata, dc_rvalid, dc_done, dc_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_rvalid, ic_done, ic_stall,
           dc_beat, dc_rdata, dc_rvalid, dc_done, dc_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/writebacks, each served as a BLOCK_WORDS-beat burst.
//
// state    | meaning
// IDLE     | no burst; requests sampled, winner latched on exit
// BURST_IC | I-cache refill beats in flight
// BURST_DC | D-cache refill or writeback beats in flight
// DONE     | one-cycle done pulse to the granted side, requests ignored
module cache_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.master  bus
);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = $clog2(BLOCK_WORDS * 4);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST_IC, BURST_DC, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat;
  logic              last_dc;
  logic [ADDR_W-1:0] base;
  logic              we_q;
  logic              bursting;
  logic              grant;
  logic              done_ic;
  logic              done_dc;

  assign bursting = (state == BURST_IC) || (state == BURST_DC);
  assign grant    = (state == IDLE) && (state_nxt != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (bus.ic_req && bus.dc_req) state_nxt = last_dc ? BURST_IC : BURST_DC;
        else if (bus.ic_req)          state_nxt = BURST_IC;
        else if (bus.dc_req)          state_nxt = BURST_DC;
      end
      BURST_IC, BURST_DC: begin
        if (bus.mem_ready && (beat == LAST_BEAT)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat    <= '0;
      last_dc <= 1'b0;
      base    <= '0;
      we_q    <= 1'b0;
    end else if (grant) begin
      beat    <= '0;
      last_dc <= (state_nxt == BURST_DC);
      if (state_nxt == BURST_DC) begin
        base <= {bus.dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        we_q <= bus.dc_we;
      end else begin
        base <= {bus.ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        we_q <= 1'b0;
      end
    end else if (bursting && bus.mem_ready) begin
      beat <= beat + 1'b1;
    end
  end

  always_comb begin
    done_ic = (state == DONE) && !last_dc;
    done_dc = (state == DONE) && last_dc;

    bus.mem_req   = bursting;
    bus.mem_we    = bursting && we_q;
    bus.mem_addr  = bursting ? (base + (ADDR_W'(beat) << 2)) : '0;
    bus.mem_wdata = ((state == BURST_DC) && we_q) ? bus.dc_wdata : '0;

    bus.ic_rvalid = (state == BURST_IC) && bus.mem_ready;
    bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
    bus.ic_done   = done_ic;
    bus.ic_stall  = bus.ic_req && !done_ic;

    bus.dc_rvalid = (state == BURST_DC) && !we_q && bus.mem_ready;
    bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;
    bus.dc_beat   = (state == BURST_DC) ? beat : '0;
    bus.dc_done   = done_dc;
    bus.dc_stall  = bus.dc_req && !done_dc;
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: a transaction-level model predicts
// grant order, beat addresses, data and done/stall timing for every cycle.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  localparam int BW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] MASK = 32'(BW * 4 - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) bus ();
  cache_mem_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [DW-1:0] mem_words [0:255];
  assign bus.mem_rdata = mem_words[bus.mem_addr[9:2]];
  assign bus.dc_wdata  = {16'hD0C0, bus.dc_addr[15:0] ^ 16'(bus.dc_beat)};

  typedef struct {
    bit          dc;
    bit          we;
    logic [31:0] base;
    logic [31:0] raw;
  } tx_t;

  tx_t q[$];
  bit  last_dc_m;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wpat(input logic [31:0] a, input int b);
    return {16'hD0C0, a[15:0] ^ 16'(b)};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, ".mem_req"},   bus.mem_req,   0);
    chk({tag, ".mem_we"},    bus.mem_we,    0);
    chk({tag, ".mem_addr"},  bus.mem_addr,  0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".ic_rvalid"}, bus.ic_rvalid, 0);
    chk({tag, ".ic_rdata"},  bus.ic_rdata,  0);
    chk({tag, ".ic_done"},   bus.ic_done,   0);
    chk({tag, ".ic_stall"},  bus.ic_stall,  0);
    chk({tag, ".dc_beat"},   bus.dc_beat,   0);
    chk({tag, ".dc_rvalid"}, bus.dc_rvalid, 0);
    chk({tag, ".dc_rdata"},  bus.dc_rdata,  0);
    chk({tag, ".dc_done"},   bus.dc_done,   0);
    chk({tag, ".dc_stall"},  bus.dc_stall,  0);
  endtask

  // rmode: 0 ready always, 1 toggling, 2 random, 3 ten-cycle stall at beat 1
  task automatic run_round(input bit do_ic, input bit do_dc, input logic [31:0] ia,
                           input logic [31:0] da, input bit dwe, input int rmode,
                           input bit hold_extra);
    tx_t ti, td, c;
    bit ic_on, dc_on, ready, tog, hold_used, exp_req, exp_done;
    int idle_left, beats, cyc, stall_run;
    logic [31:0] ea;
    ti = '{dc: 1'b0, we: 1'b0, base: ia & ~MASK, raw: ia};
    td = '{dc: 1'b1, we: dwe,  base: da & ~MASK, raw: da};
    q.delete();
    if (do_ic && do_dc) begin
      if (last_dc_m) begin q.push_back(ti); q.push_back(td); end
      else           begin q.push_back(td); q.push_back(ti); end
    end else if (do_ic) q.push_back(ti);
    else if (do_dc)     q.push_back(td);
    idle_left = 1; beats = 0; cyc = 0; stall_run = 0; tog = 1'b1; hold_used = 1'b0;
    ic_on = do_ic; dc_on = do_dc;

    @(posedge clk); #1;
    bus.ic_req = ic_on; bus.ic_addr = ia;
    bus.dc_req = dc_on; bus.dc_we = dwe; bus.dc_addr = da;
    while (q.size() > 0 && cyc < 300) begin
      c = q[0];
      case (rmode)
        0: ready = 1'b1;
        1: begin ready = tog; tog = !tog; end
        2: ready = 1'($urandom_range(0, 1));
        default: begin
          if (idle_left == 0 && beats == 1 && stall_run < 10) begin
            ready = 1'b0; stall_run++;
          end else ready = 1'b1;
        end
      endcase
      bus.mem_ready = ready;
      // The granted I-cache address is already latched; wiggle it.
      if (!c.dc && !hold_extra && idle_left == 0 && beats == 1) bus.ic_addr = $urandom;

      @(negedge clk);
      exp_req  = (idle_left == 0) && (beats < BW);
      exp_done = (beats == BW);
      chk("mem_req",  bus.mem_req,  exp_req);
      chk("ic_done",  bus.ic_done,  exp_done && !c.dc);
      chk("dc_done",  bus.dc_done,  exp_done && c.dc);
      chk("ic_stall", bus.ic_stall, ic_on && !(exp_done && !c.dc));
      chk("dc_stall", bus.dc_stall, dc_on && !(exp_done && c.dc));
      if (exp_req) begin
        ea = c.base + 32'(beats * 4);
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_we",    bus.mem_we,    c.we);
        chk("dc_beat",   bus.dc_beat,   c.dc ? beats : 0);
        chk("mem_wdata", bus.mem_wdata, c.we ? wpat(c.raw, beats) : 32'd0);
        chk("ic_rvalid", bus.ic_rvalid, ready && !c.dc);
        chk("dc_rvalid", bus.dc_rvalid, ready && c.dc && !c.we);
        if (ready && !c.we) begin
          if (c.dc) chk("dc_rdata", bus.dc_rdata, mem_words[ea[9:2]]);
          else      chk("ic_rdata", bus.ic_rdata, mem_words[ea[9:2]]);
        end
        if (ready) begin
          if (c.we) mem_words[ea[9:2]] = wpat(c.raw, beats);
          beats++;
        end
      end else begin
        chk("ic_rvalid_idle", bus.ic_rvalid, 0);
        chk("dc_rvalid_idle", bus.dc_rvalid, 0);
        chk("dc_beat_idle",   bus.dc_beat,   0);
        if (idle_left > 0) idle_left--;
        else if (exp_done) begin
          void'(q.pop_front());
          last_dc_m = c.dc;
          if (hold_extra && !hold_used && q.size() == 0) begin
            hold_used = 1'b1;
            q.push_back(c);
          end else if (c.dc) begin
            dc_on = 1'b0; bus.dc_req = 1'b0;
          end else begin
            ic_on = 1'b0; bus.ic_req = 1'b0;
          end
          idle_left = 1; beats = 0;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk("round_pending", q.size(), 0);
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", bus.mem_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, a2;
    int sel;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    rst = 1'b1;
    bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = 0;
    bus.mem_ready = 0;
    last_dc_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    run_round(1, 1, 32'h0000_0104, 32'h0000_0208, 1'b0, 0, 1'b0);
    run_round(1, 1, 32'h0000_0330, 32'h0000_0018, 1'b1, 2, 1'b0);
    run_round(1, 0, 32'h0000_1234, 32'h0,         1'b0, 0, 1'b0);
    run_round(0, 1, 32'h0,         32'h0000_2000, 1'b1, 1, 1'b0);
    run_round(0, 1, 32'h0,         32'h0000_2004, 1'b0, 0, 1'b0);
    run_round(1, 0, 32'h0000_0088, 32'h0,         1'b0, 0, 1'b1);
    run_round(1, 0, 32'h0000_0190, 32'h0,         1'b0, 3, 1'b0);

    // Reset during beat 2 of an I-cache burst.
    @(posedge clk); #1;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0040; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_beat2_addr", bus.mem_addr, 32'h0000_0048);
    rst = 1'b1; bus.ic_req = 1'b0;
    @(posedge clk); #1;
    check_quiet("mid_reset");
    rst = 1'b0;
    last_dc_m = 1'b0;
    run_round(0, 1, 32'h0, 32'h0000_03F0, 1'b0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(1, 3);
      a1 = $urandom & 32'h3FF;
      a2 = $urandom & 32'h3FF;
      run_round(sel[0], sel[1], a1, a2, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sequences each granted request as a burst of BLOCK_WORDS word beats over a ready-handshaked memory port.
- Raises per-cache stall lines toward the hazard detection unit, which freezes the pipeline registers while a miss is serviced.

Parameters:
- BLOCK_WORDS, 4: words per cache block. Power of two, 2..16.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  I-cache refill request. Held until ic_done.
- ic_addr  in  ADDR_W  I-cache miss address (any byte in block)
- ic_rdata  out  DATA_W  refill word, valid with ic_rvalid
- ic_rvalid  out  1  one pulse per returned I-cache word
- ic_done  out  1  one-cycle pulse, I-cache burst complete
- ic_stall  out  1  I-cache miss outstanding
- dc_req  in  1  D-cache request. Held until dc_done.
- dc_we  in  1  1 = writeback burst, 0 = refill. Stable while dc_req is high.
- dc_addr  in  ADDR_W  D-cache block address (any byte in block)
- dc_wdata  in  DATA_W  writeback word for beat dc_beat
- dc_beat  out  clog2(BLOCK_WORDS)  current beat index, used to select dc_wdata
- dc_rdata  out  DATA_W  refill word, valid with dc_rvalid
- dc_rvalid  out  1  one pulse per returned D-cache word
- dc_done  out  1  one-cycle pulse, D-cache burst complete
- dc_stall  out  1  D-cache request outstanding
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  beat accepted/completed this cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - state IDLE, beat counter 0, last_grant = IC.
  - All outputs 0, including mem_req, done, rvalid and stall.
  - Reset mid-burst abandons the burst with no done pulse. Requesters re-request after reset.
- States: IDLE, BURST_IC, BURST_DC, DONE.
- IDLE transitions:
  - Only ic_req → BURST_IC.
  - Only dc_req → BURST_DC.
  - Both → the one not equal to last_grant (round-robin). After reset DC wins the first tie.
  - On entry to a burst: latch the aligned base = addr with low log2(BLOCK_WORDS*4) bits cleared, latch dc_we (forced to 0 for IC), clear the beat counter, set last_grant.
- BURST_x:
  - mem_req=1, mem_addr = base + 4*beat, mem_we = latched we.
  - mem_wdata = dc_wdata when a DC write is granted, else 0.
  - A beat completes in a cycle with mem_ready=1. Then beat increments. On a read, x_rdata = mem_rdata and x_rvalid=1 in that same cycle (combinational pass-through).
  - mem_ready=0 holds all outputs stable. There are no timeouts.
  - A completed beat with beat = BLOCK_WORDS-1 → DONE, beat wraps to 0.
- DONE:
  - Lasts exactly one cycle, mem_req=0, x_done=1 for the granted side.
  - Requests are not sampled in DONE.
  - Next state is IDLE.
  - The requester drops req at the edge ending DONE. If req is still high in IDLE, it is treated as a new request.
- dc_beat mirrors the beat counter during BURST_DC and is 0 otherwise.
- Stall lines:
  - ic_stall = ic_req & ~ic_done; dc_stall = dc_req & ~dc_done (combinational from registered done).
  - Both may be high together; the ungranted side keeps stalling.
- Inputs are ignored while not granted. Address changes during a burst have no effect because base is latched.
- Minimum burst latency is BLOCK_WORDS+2 cycles from req seen in IDLE to done: 1 grant cycle, BLOCK_WORDS beats, 1 DONE cycle.

Test Plan:
- Single IC refill: ic_req, ic_addr=0x0000_1234, mem_ready always 1.
  - Expect mem_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles.
  - Expect 4 ic_rvalid pulses, ic_done in cycle 6, then ic_stall=0.
- DC writeback with mem_ready toggling 1,0,1,0…: dc_we=1, dc_addr=0x2000.
  - Expect mem_we=1 and dc_beat 0..3 each held across wait cycles.
  - Expect mem_wdata to track dc_wdata and dc_done after the 4th ready.
- Simultaneous ic_req and dc_req right after reset:
  - DC is granted first and ic_stall stays 1 throughout.
  - IC is granted on the IDLE following DC's DONE.
  - A second simultaneous pair is then served DC→IC again, per last_grant alternation.
- Requester holds req through DONE for one extra cycle: a second burst starts at the same aligned base.
- rst asserted during beat 2 of an IC burst:
  - Next cycle all outputs are 0 and state is IDLE, with no ic_done.
  - After rst drops with dc_req high, DC is granted.
- mem_ready held 0 for 10 cycles mid-burst: mem_addr, mem_req and beat stay constant, with no rvalid pulses.
